wrt_track: RTL and testbench
============================

# wrt_track

Pipeline write-tracking block: records every instruction issued out of fetch and shifts its destination-register and branch information through the D, X, M and W slots. It is the producer side of the stall interface: it drives the per-stage `regWrt*`, `wrtReg*` and `branchInst*` signals that the hazard detector compares against the fetched instruction. It also keeps a per-register pending-write count so the front end can query whether any register has a write in flight.

## Interface

Parameters:
- `NREG`, default 8: number of architectural registers.
- `RW`, default 3: register-index width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  an instruction is issued from fetch into D this cycle. Injected NOPs drive 0.
- `in_regWrt`  in  1  the issued instruction writes a register.
- `in_wrtReg`  in  RW  destination register of the issued instruction.
- `in_branch`  in  1  the issued instruction is a branch or jump.
- `freeze`  in  1  memory stall; all four slots hold their contents.
- `flush`  in  1  branch resolved redirect; squashes D, X and the current input.
- `regWrtD/X/M/W`  out  1  the slot holds a valid register writer.
- `wrtRegD/X/M/W`  out  RW  destination register held in the slot.
- `branchInstD/X/M/W`  out  1  the slot holds a valid branch.
- `busy`  out  NREG  bit r is 1 when cnt[r] != 0.
- `retire_valid`  out  1  the W slot held a valid writer that left this cycle.

## Operation

Slot contents:
- Each slot holds {v, wr, rd, br}.
- Slot outputs are registered: `regWrt* = v & wr`, `wrtReg* = rd`, `branchInst* = v & br`.

Per-edge update, in priority order:
1. `rst_n`=0: every slot becomes {0,0,0,0}; every cnt[r] becomes 0.
2. `freeze`=1, `flush`=0: all slots hold; inputs are ignored; counters hold.
3. `freeze`=1, `flush`=1: D and X become bubbles; M and W hold; counters decrement for the squashed D and X writers.
4. `flush`=1, `freeze`=0:
   - W <= M, M <= bubble, X <= bubble, D <= bubble.
   - Counters decrement for the D, X and W writers.
   - The input is dropped.
5. Normal: W <= M, M <= X, X <= D, D <= input. The input's `v` is `in_valid`; `wr` and `br` are zeroed when `in_valid`=0.

Counters:
- cnt[r] is 3 bits. In-flight writers per register are at most 4.
- cnt[r] next = cnt[r] + inc[r] − dec[r], where:
  - inc is at most 1 (an accepted input writer).
  - dec is at most 3 (the retiring W writer plus squashed D/X writers).
- The same register incremented and decremented in one cycle nets correctly; for example, input writes r2 while W retires r2 gives no change.
- Underflow or overflow is a design error. Add an assertion: cnt never goes negative and never exceeds 4.
- Invariant: cnt[r] equals the number of valid slots with wr=1 and rd=r.

Retirement:
- `retire_valid` is registered. It is 1 the cycle after the W slot held a writer and the slot advanced, either by a normal shift or by a flush shift.
- While frozen, W does not advance, so `retire_valid` stays 0.

## Timing

- Latency:
  - Input accepted at edge N appears on the D outputs after edge N.
  - It reaches the W outputs after edge N+3, provided there is no freeze.
- `busy[r]` rises the cycle after the accepting edge.
- `busy[r]` falls the cycle after the last writer to r leaves W or is squashed.
- All outputs are 0 during reset and immediately after reset deassertion.
- Reset asserted mid-operation clears all state asynchronously. Pending writes are discarded, not retired.
- Freeze of any length is lossless. Contents resume shifting on the first edge with `freeze`=0.
- Flush is a single-cycle event. A flush held for k cycles keeps D, X and M empty and drains W normally each cycle.

## Test plan

- Reset then idle: hold `rst_n`=0 for 2 cycles, release, and drive `in_valid`=0 for 5 cycles → all slot outputs 0, `busy`=8'h00, `retire_valid` never 1.
- Shift: issue a writer to r3 at edge 0.
  - After edge 0: `regWrtD`=1, `wrtRegD`=3, `busy`=8'h08.
  - After edge 3: the writer appears in W.
  - After edge 4: `retire_valid`=1, `busy`=8'h00.
- Double writer: issue r5 writers at edges 0 and 1 → cnt[5]=2. `busy[5]` stays 1 until after edge 5, then drops to 0.
- Freeze: with a writer to r1 in X, assert `freeze` for 3 cycles → `wrtRegX`=1 holds and `busy[1]`=1. After release, the writer reaches W 2 edges later.
- Flush:
  - Setup: D=r2 writer, X=r4 branch+writer, M=r6 writer, input=r7 writer.
  - Assert `flush` → D=0, X=0, M=0, W=r6.
  - `busy` = 8'h40; cnt[2], cnt[4] and cnt[7] are 0.
- Simultaneous events:
  - Input writes r2 while W retires r2 → cnt[2] unchanged.
  - Freeze+flush together → D and X cleared, M and W held.

Source files
------------

// File: rtl/wrt_track.sv
// Pipeline write tracker: shifts issued-instruction destination/branch info through D, X, M, W
// and keeps a per-register count of writes still in flight.
module wrt_track #(
    parameter int NREG = 8,
    parameter int RW   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            in_regWrt,
    input  logic [RW-1:0]   in_wrtReg,
    input  logic            in_branch,
    input  logic            freeze,
    input  logic            flush,
    output logic            regWrtD,
    output logic            regWrtX,
    output logic            regWrtM,
    output logic            regWrtW,
    output logic [RW-1:0]   wrtRegD,
    output logic [RW-1:0]   wrtRegX,
    output logic [RW-1:0]   wrtRegM,
    output logic [RW-1:0]   wrtRegW,
    output logic            branchInstD,
    output logic            branchInstX,
    output logic            branchInstM,
    output logic            branchInstW,
    output logic [NREG-1:0] busy,
    output logic            retire_valid
);

    typedef struct packed {
        logic          v;
        logic          wr;
        logic [RW-1:0] rd;
        logic          br;
    } slot_t;

    slot_t      d_q, x_q, m_q, w_q;
    slot_t      d_d, x_d, m_d, w_d;
    slot_t      in_slot;
    logic       retire_q, retire_d;
    logic       acc_in;   // input enters D this edge
    logic       sq_dx;    // D and X writers are squashed this edge
    logic       ret_w;    // W advances this edge

    logic [2:0] cnt_q  [NREG];
    logic [2:0] cnt_d  [NREG];
    logic [3:0] cnt_nx [NREG];
    logic       inc    [NREG];
    logic [1:0] dec    [NREG];

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        d_d      = d_q;
        x_d      = x_q;
        m_d      = m_q;
        w_d      = w_q;
        acc_in   = 1'b0;
        sq_dx    = 1'b0;
        ret_w    = 1'b0;
        in_slot.v  = in_valid;
        in_slot.wr = in_valid & in_regWrt;
        in_slot.rd = in_wrtReg;
        in_slot.br = in_valid & in_branch;

        if (freeze) begin
            if (flush) begin
                d_d   = '0;
                x_d   = '0;
                sq_dx = 1'b1;
            end
        end else if (flush) begin
            w_d   = m_q;
            m_d   = '0;
            x_d   = '0;
            d_d   = '0;
            sq_dx = 1'b1;
            ret_w = 1'b1;
        end else begin
            w_d    = m_q;
            m_d    = x_q;
            x_d    = d_q;
            d_d    = in_slot;
            acc_in = 1'b1;
            ret_w  = 1'b1;
        end

        retire_d = ret_w & w_q.v & w_q.wr;
    end

    // Increment and all decrements are summed together so a same-register enter/leave nets to zero.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            inc[r] = acc_in & in_slot.wr & (in_slot.rd == RW'(r));
            dec[r] = 2'(ret_w & w_q.v & w_q.wr & (w_q.rd == RW'(r)))
                   + 2'(sq_dx & d_q.v & d_q.wr & (d_q.rd == RW'(r)))
                   + 2'(sq_dx & x_q.v & x_q.wr & (x_q.rd == RW'(r)));
            cnt_nx[r] = {1'b0, cnt_q[r]} + {3'b000, inc[r]} - {2'b00, dec[r]};
            cnt_d[r]  = cnt_nx[r][2:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the counters are explicitly reset
    // because pending writes must be discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q      <= '0;
            x_q      <= '0;
            m_q      <= '0;
            w_q      <= '0;
            retire_q <= 1'b0;
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            d_q      <= d_d;
            x_q      <= x_d;
            m_q      <= m_d;
            w_q      <= w_d;
            retire_q <= retire_d;
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    assign regWrtD      = d_q.v & d_q.wr;
    assign regWrtX      = x_q.v & x_q.wr;
    assign regWrtM      = m_q.v & m_q.wr;
    assign regWrtW      = w_q.v & w_q.wr;
    assign wrtRegD      = d_q.rd;
    assign wrtRegX      = x_q.rd;
    assign wrtRegM      = m_q.rd;
    assign wrtRegW      = w_q.rd;
    assign branchInstD  = d_q.v & d_q.br;
    assign branchInstX  = x_q.v & x_q.br;
    assign branchInstM  = m_q.v & m_q.br;
    assign branchInstW  = w_q.v & w_q.br;
    assign retire_valid = retire_q;

    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        assign busy[r] = |cnt_q[r];

        // A wrapped 4-bit next value (13..15) means underflow; anything above 4 means overflow.
        a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n) cnt_nx[r] <= 4'd4)
            else $error("wrt_track: cnt[%0d] out of range", r);
    end

endmodule

// File: tb/tb_wrt_track.sv
// Self-checking bench for wrt_track: directed scenarios plus randomized traffic against a slot-list model.
module tb_wrt_track;

    localparam int NREG = 8;
    localparam int RW   = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_regWrt, in_branch, freeze, flush;
    logic [RW-1:0]   in_wrtReg;
    logic            regWrtD, regWrtX, regWrtM, regWrtW;
    logic [RW-1:0]   wrtRegD, wrtRegX, wrtRegM, wrtRegW;
    logic            branchInstD, branchInstX, branchInstM, branchInstW;
    logic [NREG-1:0] busy;
    logic            retire_valid;

    int n_checks = 0;
    int n_pass   = 0;

    wrt_track #(.NREG(NREG), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_regWrt(in_regWrt), .in_wrtReg(in_wrtReg), .in_branch(in_branch),
        .freeze(freeze), .flush(flush),
        .regWrtD(regWrtD), .regWrtX(regWrtX), .regWrtM(regWrtM), .regWrtW(regWrtW),
        .wrtRegD(wrtRegD), .wrtRegX(wrtRegX), .wrtRegM(wrtRegM), .wrtRegW(wrtRegW),
        .branchInstD(branchInstD), .branchInstX(branchInstX),
        .branchInstM(branchInstM), .branchInstW(branchInstW),
        .busy(busy), .retire_valid(retire_valid)
    );

    always #5 clk = ~clk;

    // Reference model: four instruction records, index 0 = D ... 3 = W.
    typedef struct {
        bit       v;
        bit       wr;
        bit [2:0] rd;
        bit       br;
    } ins_t;

    ins_t pipe[4];
    bit   m_ret;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) pipe[i] = '{0, 0, 0, 0};
        m_ret = 0;
    endtask

    task automatic model_step(bit iv, bit iw, bit [2:0] ird, bit ib, bit frz, bit fl);
        ins_t bub = '{0, 0, 0, 0};
        if (frz) begin
            m_ret = 0;
            if (fl) begin
                pipe[0] = bub;
                pipe[1] = bub;
            end
        end else begin
            m_ret   = pipe[3].v && pipe[3].wr;
            pipe[3] = pipe[2];
            if (fl) begin
                pipe[2] = bub;
                pipe[1] = bub;
                pipe[0] = bub;
            end else begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = '{iv, iv & iw, ird, iv & ib};
            end
        end
    endtask

    // Busy bits derived from counting in-flight writers in the model.
    function automatic logic [7:0] model_busy();
        logic [7:0] b = '0;
        for (int r = 0; r < NREG; r++) begin
            int n = 0;
            for (int i = 0; i < 4; i++)
                if (pipe[i].v && pipe[i].wr && pipe[i].rd == 3'(r)) n++;
            b[r] = (n != 0);
        end
        return b;
    endfunction

    function automatic logic [28:0] exp_vec();
        logic [28:0] e;
        e = '0;
        for (int i = 0; i < 4; i++)
            e[28 - 5*i -: 5] = {pipe[i].v & pipe[i].wr, pipe[i].rd, pipe[i].v & pipe[i].br};
        e[8:1] = model_busy();
        e[0]   = m_ret;
        return e;
    endfunction

    function automatic logic [28:0] obs_vec();
        return {regWrtD, wrtRegD, branchInstD, regWrtX, wrtRegX, branchInstX,
                regWrtM, wrtRegM, branchInstM, regWrtW, wrtRegW, branchInstW,
                busy, retire_valid};
    endfunction

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic step(bit iv, bit iw, bit [2:0] ird, bit ib, bit frz, bit fl);
        in_valid  = iv;
        in_regWrt = iw;
        in_wrtReg = ird;
        in_branch = ib;
        freeze    = frz;
        flush     = fl;
        @(posedge clk);
        model_step(iv, iw, ird, ib, frz, fl);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        in_valid = 0; in_regWrt = 0; in_wrtReg = 0; in_branch = 0; freeze = 0; flush = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs_vec() !== 29'd0) $display("FAIL reset_hold: got %h want 0", obs_vec());
        else n_pass++;
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0);
            n_checks++;
            if (obs_vec() !== 29'd0 || obs_vec() !== exp_vec())
                $display("FAIL reset_idle[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_shift();
        step(1, 1, 3, 0, 0, 0);
        n_checks++;
        if ({regWrtD, wrtRegD, busy} !== {1'b1, 3'd3, 8'h08})
            $display("FAIL shift_d: got %b/%0d/%h want 1/3/08", regWrtD, wrtRegD, busy);
        else n_pass++;
        idle(3);
        n_checks++;
        if ({regWrtW, wrtRegW, regWrtD} !== {1'b1, 3'd3, 1'b0})
            $display("FAIL shift_w: got %b/%0d want 1/3", regWrtW, wrtRegW);
        else n_pass++;
        idle(1);
        n_checks++;
        if ({retire_valid, busy, regWrtW} !== {1'b1, 8'h00, 1'b0})
            $display("FAIL shift_retire: got ret=%b busy=%h want ret=1 busy=00", retire_valid, busy);
        else n_pass++;
        idle(1);
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL shift_after: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_double_writer();
        step(1, 1, 5, 0, 0, 0);
        step(1, 1, 5, 0, 0, 0);
        for (int e = 2; e <= 5; e++) begin
            step(0, 0, 0, 0, 0, 0);
            n_checks++;
            if (busy[5] !== (e < 5) || obs_vec() !== exp_vec())
                $display("FAIL double_busy[edge%0d]: got busy=%h want bit5=%0d (vec %h vs %h)",
                         e, busy, (e < 5), obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_freeze();
        step(1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 6, 1, 1, 0);
            n_checks++;
            if ({regWrtX, wrtRegX, busy[1], regWrtD, retire_valid} !== {1'b1, 3'd1, 1'b1, 1'b0, 1'b0})
                $display("FAIL freeze_hold[%0d]: got X=%b/%0d busy=%h D=%b", i, regWrtX, wrtRegX, busy, regWrtD);
            else n_pass++;
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({regWrtW, wrtRegW} !== {1'b1, 3'd1} || obs_vec() !== exp_vec())
            $display("FAIL freeze_release: got W=%b/%0d want 1/1", regWrtW, wrtRegW);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_flush();
        step(1, 1, 6, 0, 0, 0);
        step(1, 1, 4, 1, 0, 0);
        step(1, 1, 2, 0, 0, 0);
        n_checks++;
        if (busy !== 8'h54) $display("FAIL flush_setup: got busy=%h want 54", busy);
        else n_pass++;
        step(1, 1, 7, 0, 0, 1);
        n_checks++;
        if ({regWrtD, regWrtX, regWrtM, branchInstX, regWrtW, wrtRegW, busy}
            !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 8'h40})
            $display("FAIL flush: got D=%b X=%b M=%b W=%b/%0d busy=%h want 0 0 0 1/6 busy=40",
                     regWrtD, regWrtX, regWrtM, regWrtW, wrtRegW, busy);
        else n_pass++;
        idle(1);
        n_checks++;
        if ({retire_valid, busy} !== {1'b1, 8'h00})
            $display("FAIL flush_drain: got ret=%b busy=%h want 1/00", retire_valid, busy);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [RW+1:0] m_before, w_before;
        step(1, 1, 2, 0, 0, 0);
        idle(3);
        step(1, 1, 2, 0, 0, 0);
        n_checks++;
        if ({retire_valid, busy, regWrtD, wrtRegD, regWrtW} !== {1'b1, 8'h04, 1'b1, 3'd2, 1'b0})
            $display("FAIL same_reg_net: got ret=%b busy=%h D=%b/%0d", retire_valid, busy, regWrtD, wrtRegD);
        else n_pass++;
        step(1, 1, 3, 0, 0, 0);
        step(1, 1, 5, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        m_before = {regWrtM, wrtRegM, branchInstM};
        w_before = {regWrtW, wrtRegW, branchInstW};
        step(1, 1, 1, 0, 1, 1);
        n_checks++;
        if ({regWrtD, regWrtX, branchInstX, retire_valid} !== 4'b0000 ||
            {regWrtM, wrtRegM, branchInstM} !== m_before ||
            {regWrtW, wrtRegW, branchInstW} !== w_before || busy !== 8'h0c)
            $display("FAIL freeze_flush: got D=%b X=%b M=%b/%0d W=%b/%0d busy=%h want busy=0c",
                     regWrtD, regWrtX, regWrtM, wrtRegM, regWrtW, wrtRegW, busy);
        else n_pass++;
        idle(4);
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            bit frz = ($urandom_range(0, 9) < 2);
            bit fl  = ($urandom_range(0, 9) == 0);
            step(1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), frz, fl);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                if (errs < 10) $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
                errs++;
            end else n_pass++;
        end
        // Asynchronous reset in the middle of traffic clears everything at once.
        step(1, 1, 4, 0, 0, 0);
        #2 rst_n = 0;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec() !== 29'd0) $display("FAIL async_reset: got %h want 0", obs_vec());
        else n_pass++;
        @(negedge clk);
        rst_n = 1;
        idle(2);
        n_checks++;
        if (obs_vec() !== 29'd0) $display("FAIL post_reset: got %h want 0", obs_vec());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_shift();
        test_double_writer();
        test_freeze();
        test_flush();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
